// File: rtl/swlw_report_collector.sv
// Report collector for the swlw automata stage.
// Ports: clk, reset (async, active-high), run, clear_sticky, symbols_in, reports_in
//   -> event FIFO (rpt_valid/rpt_ready, rpt_vector/symbol/index, fifo_count)
//   -> sticky_reports, overflow, drop_count.
module swlw_report_collector #(
  parameter int NUM_REPORTS = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 32,
  parameter int DROP_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          clear_sticky,
  input  logic [7:0]                    symbols_in,
  input  logic [NUM_REPORTS-1:0]        reports_in,
  output logic                          rpt_valid,
  input  logic                          rpt_ready,
  output logic [NUM_REPORTS-1:0]        rpt_vector,
  output logic [7:0]                    rpt_symbol,
  output logic [CNT_W-1:0]              rpt_index,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [NUM_REPORTS-1:0]        sticky_reports,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  logic [NUM_REPORTS-1:0] mem_vec_q [FIFO_DEPTH];
  logic [7:0]             mem_sym_q [FIFO_DEPTH];
  logic [CNT_W-1:0]       mem_idx_q [FIFO_DEPTH];

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CNT_W-1:0]       sym_idx_q, sym_idx_d;
  logic [NUM_REPORTS-1:0] sticky_q, sticky_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;

  logic push_req, pop, full, push_ok, drop;
  logic [NUM_REPORTS-1:0] run_rep;

  assign rpt_valid = (count_q != '0);
  assign full      = (count_q == FULL_C);
  assign pop       = rpt_valid & rpt_ready;
  assign push_req  = run & (|reports_in);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign run_rep   = run ? reports_in : '0;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sym_idx_d = sym_idx_q;
    sticky_d  = sticky_q | run_rep;
    ovf_d     = ovf_q | drop;
    drop_d    = drop_q;
    if (run) sym_idx_d = sym_idx_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
    // Same-cycle report or drop survives a clear.
    if (clear_sticky) begin
      sticky_d = run_rep;
      ovf_d    = drop;
      drop_d   = drop ? DROP_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sym_idx_q <= '0;
      sticky_q  <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sym_idx_q <= sym_idx_d;
      sticky_q  <= sticky_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_vec_q[wr_ptr_q] <= reports_in;
      mem_sym_q[wr_ptr_q] <= symbols_in;
      mem_idx_q[wr_ptr_q] <= sym_idx_q;
    end
  end

  assign rpt_vector     = rpt_valid ? mem_vec_q[rd_ptr_q] : '0;
  assign rpt_symbol     = rpt_valid ? mem_sym_q[rd_ptr_q] : '0;
  assign rpt_index      = rpt_valid ? mem_idx_q[rd_ptr_q] : '0;
  assign fifo_count     = count_q;
  assign sticky_reports = sticky_q;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_swlw_report_collector.sv
// Randomized bench for swlw_report_collector against a queue-based model.
// A second instance with CNT_W=4 shares all inputs to cover index wrap.
module tb_swlw_report_collector;

  logic        clk = 1'b0;
  logic        reset, run, clr, ready;
  logic [7:0]  sym;
  logic [15:0] rep;

  logic        v32, v4, ovf32, ovf4;
  logic [15:0] vec32, vec4, st32, st4, dc32, dc4;
  logic [7:0]  s32, s4;
  logic [31:0] i32;
  logic [3:0]  i4;
  logic [3:0]  c32, c4;

  swlw_report_collector dut (
    .clk(clk), .reset(reset), .run(run), .clear_sticky(clr),
    .symbols_in(sym), .reports_in(rep),
    .rpt_valid(v32), .rpt_ready(ready), .rpt_vector(vec32),
    .rpt_symbol(s32), .rpt_index(i32), .fifo_count(c32),
    .sticky_reports(st32), .overflow(ovf32), .drop_count(dc32)
  );

  swlw_report_collector #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .clear_sticky(clr),
    .symbols_in(sym), .reports_in(rep),
    .rpt_valid(v4), .rpt_ready(ready), .rpt_vector(vec4),
    .rpt_symbol(s4), .rpt_index(i4), .fifo_count(c4),
    .sticky_reports(st4), .overflow(ovf4), .drop_count(dc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]    v;
    logic [7:0]     s;
    longint unsigned i;
  } ev_t;

  ev_t             q[$];
  longint unsigned m_idx;
  logic [15:0]     m_sticky;
  logic            m_ovf;
  int              m_drop;
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx    = 0;
    m_sticky = '0;
    m_ovf    = 1'b0;
    m_drop   = 0;
  endtask

  // Spec rules applied to the inputs present at the clock edge.
  task automatic model_edge();
    bit do_pop, do_push, dropped;
    do_pop  = (q.size() != 0) && ready;
    do_push = run && (rep != 0);
    dropped = do_push && q.size() == 8 && !do_pop;
    if (clr) begin
      m_sticky = '0;
      m_ovf    = 1'b0;
      m_drop   = 0;
    end
    if (run) m_sticky |= rep;
    if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push && !dropped) q.push_back('{v: rep, s: sym, i: m_idx});
    if (run) m_idx++;
  endtask

  task automatic check_all();
    chk("valid", 64'(v32), 64'(q.size() != 0));
    chk("valid4", 64'(v4), 64'(q.size() != 0));
    chk("count", 64'(c32), 64'(q.size()));
    if (q.size() != 0) begin
      chk("vector", 64'(vec32), 64'(q[0].v));
      chk("symbol", 64'(s32), 64'(q[0].s));
      chk("index", 64'(i32), q[0].i & 64'hFFFF_FFFF);
      chk("index4", 64'(i4), q[0].i & 64'hF);
    end
    chk("sticky", 64'(st32), 64'(m_sticky));
    chk("overflow", 64'(ovf32), 64'(m_ovf));
    chk("drops", 64'(dc32), 64'(m_drop));
  endtask

  // Inputs are already driven; advance one edge and check at the negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic r, input logic [15:0] rp,
                       input logic [7:0] s, input logic rd,
                       input logic c);
    run = r; rep = rp; sym = s; ready = rd; clr = c;
  endtask

  function automatic logic [15:0] rnd_rep();
    logic [15:0] x;
    x = 16'($urandom);
    if (x == 0) x = 16'h0100;
    return x;
  endfunction

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all();
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // 1: first event after 5 idle run cycles
    drive(1'b1, '0, 8'h00, 1'b0, 1'b0);
    repeat (5) step();
    drive(1'b1, 16'h0010, 8'h3A, 1'b0, 1'b0);
    step();
    chk("t1_valid", 64'(v32), 64'd1);
    chk("t1_index", 64'(i32), 64'd5);
    chk("t1_symbol", 64'(s32), 64'h3A);
    drain();

    // 2: fill, overflow by 3, drain in order
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, rnd_rep(), 8'($urandom), 1'b0, 1'b0);
      step();
    end
    chk("t2_count", 64'(c32), 64'd8);
    chk("t2_ovf", 64'(ovf32), 64'd1);
    chk("t2_drops", 64'(dc32), 64'd3);
    drain();

    // 3: push+pop while full
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, rnd_rep(), 8'($urandom), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 16'h0420, 8'h55, 1'b1, 1'b0);
    step();
    chk("t3_count", 64'(c32), 64'd8);
    chk("t3_drops", 64'(dc32), 64'd3);
    drain();

    // 4: run toggles with a held report
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'h8001, 8'h11, 1'b0, 1'b0); step();
    drive(1'b0, 16'h8001, 8'h12, 1'b0, 1'b0); step();
    drive(1'b1, 16'h8001, 8'h13, 1'b0, 1'b0); step();
    chk("t4_count", 64'(c32), 64'd2);
    chk("t4_sticky", 64'(st32), 64'h8001);
    drain();

    // 5: clear with a same-cycle report
    drive(1'b1, 16'h0002, 8'h22, 1'b1, 1'b1);
    step();
    chk("t5_sticky", 64'(st32), 64'h0002);
    chk("t5_ovf", 64'(ovf32), 64'd0);
    drain();

    // 6: async reset with 4 entries held
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, rnd_rep(), 8'($urandom), 1'b0, 1'b0);
      step();
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 64'(v32), 64'd0);
    chk("t6_count", 64'(c32), 64'd0);
    chk("t6_vector", 64'(vec32), 64'd0);
    chk("t6_sticky", 64'(st32), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 16'h0008, 8'h77, 1'b0, 1'b0);
    step();
    chk("t6_index0", 64'(i32), 64'd0);
    drain();

    // 7: 4-bit index wraps after 16 run cycles
    do_reset();
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    repeat (16) step();
    drive(1'b1, 16'h0001, 8'h99, 1'b0, 1'b0);
    step();
    chk("t7_wrap4", 64'(i4), 64'd0);
    chk("t7_idx32", 64'(i32), 64'd16);
    drain();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 16'h0 : rnd_rep(),
            8'($urandom),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 19) == 0));
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
